// File: rtl/mmio_fact_responder.sv
// Memory-mapped factorial accelerator: the processor writes n and a GO pulse,
// polls STATUS, then reads n! from RESULT. Reads are combinational from the offset.
module mmio_fact_responder #(
   parameter int DW    = 32,
   parameter int NW    = 4,
   parameter int MAX_N = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [1:0]    a,
   input  logic [DW-1:0] wd,
   output logic [DW-1:0] rd,
   output logic          busy
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [NW-1:0] MAX_N_W = NW'(MAX_N);
   localparam logic [NW-1:0] ONE_N   = NW'(1);

   state_t        state_q, state_d;
   logic [NW-1:0] n_q, n_d;
   logic [NW-1:0] cnt_q, cnt_d;
   logic          go_q, go_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [DW-1:0] result_q, result_d;
   logic [DW-1:0] prod_q, prod_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         n_q      <= '0;
         cnt_q    <= '0;
         go_q     <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         result_q <= '0;
         prod_q   <= '0;
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         cnt_q    <= cnt_d;
         go_q     <= go_d;
         done_q   <= done_d;
         err_q    <= err_d;
         result_q <= result_d;
         prod_q   <= prod_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      cnt_d    = cnt_q;
      go_d     = go_q;
      done_d   = done_q;
      err_d    = err_q;
      result_d = result_q;
      prod_d   = prod_q;

      if (we && a == 2'd0) begin
         n_d = wd[NW-1:0];
      end

      case (state_q)
         IDLE: begin
            if (we && a == 2'd1 && wd[0]) begin
               go_d = 1'b1;
            end
            // A pending start is consumed here; it takes precedence over a
            // GO write landing on the same edge.
            if (go_q) begin
               go_d     = 1'b0;
               done_d   = 1'b0;
               err_d    = 1'b0;
               result_d = '0;
               if (n_q > MAX_N_W) begin
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end else begin
                  cnt_d   = n_q;
                  prod_d  = DW'(1);
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (cnt_q <= ONE_N) begin
               result_d = prod_q;
               done_d   = 1'b1;
               state_d  = IDLE;
            end else begin
               prod_d = prod_q * DW'(cnt_q);
               cnt_d  = cnt_q - ONE_N;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == RUN);

   always_comb begin
      rd = '0;
      case (a)
         2'd0: rd = DW'(n_q);
         2'd1: rd = DW'(go_q);
         2'd2: rd = {{(DW-2){1'b0}}, err_q, done_q};
         2'd3: rd = result_q;
         default: rd = '0;
      endcase
   end

endmodule
